// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and clamp helper
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bcd_t bcd_clamp(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD up/down digit with load, step and terminal-count out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset,
  input  logic step,
  input  logic up,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic co
);

  bcd_t q_next;

  // co reports the terminal digit for the current direction; callers gate it with their step
  assign co = up ? (q >= BCD_MAX) : (q == BCD_MIN);

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = bcd_clamp(d);
    end else if (step) begin
      if (up) begin
        q_next = (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q_next = (q == BCD_MIN) ? BCD_MAX : bcd_clamp(q - 4'd1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      q <= BCD_MIN;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/bcd_counter_2dig.sv
// rtl/bcd_counter_2dig.sv - two-digit BCD up/down counter with prescaler, load and wrap pulse
module bcd_counter_2dig
  import bcd_pkg::*;
#(
  parameter int DIV = 50_000_000,
  parameter int PW  = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic       wrap
);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          units_co;
  logic          tens_co;
  logic          tens_step;

  // load has priority, so a tick coinciding with a load is discarded
  assign tick      = en & ~load & (pre == PRE_LAST);
  assign tens_step = tick & units_co;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (load) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
  end

  bcd_digit u_units (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .step     (tick),
    .up       (up),
    .load     (load),
    .d        (load_val[3:0]),
    .q        (BCD0),
    .co       (units_co)
  );

  bcd_digit u_tens (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .step     (tens_step),
    .up       (up),
    .load     (load),
    .d        (load_val[7:4]),
    .q        (BCD1),
    .co       (tens_co)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tens_step & tens_co;
    end
  end

endmodule

// File: tb/tb_bcd_counter_2dig.sv
// tb/tb_bcd_counter_2dig.sv - self-checking bench for bcd_counter_2dig (DIV = 4)
module tb_bcd_counter_2dig;

  localparam int DIV = 4;
  localparam int PW  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  // reference: counter value 0..99 as a plain integer
  int m_val  = 0;
  int m_pre  = 0;
  int m_wrap = 0;

  bcd_counter_2dig #(.DIV(DIV), .PW(PW)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .BCD1     (BCD1),
    .BCD0     (BCD0),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val  <= 0;
      m_pre  <= 0;
      m_wrap <= 0;
    end else if (load) begin
      m_val  <= clamp9(load_val[7:4]) * 10 + clamp9(load_val[3:0]);
      m_pre  <= 0;
      m_wrap <= 0;
    end else if (en && m_pre == DIV - 1) begin
      m_pre <= 0;
      if (up) begin
        m_val  <= (m_val + 1) % 100;
        m_wrap <= (m_val == 99) ? 1 : 0;
      end else begin
        m_val  <= (m_val + 99) % 100;
        m_wrap <= (m_val == 0) ? 1 : 0;
      end
    end else begin
      if (en) m_pre <= m_pre + 1;
      m_wrap <= 0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_bcd1", int'(BCD1), m_val / 10);
    chk("model_bcd0", int'(BCD0), m_val % 10);
    chk("model_wrap", int'(wrap), m_wrap);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  task automatic lit(input string name, input int tens, input int units, input int w);
    chk({name, "_bcd1"}, int'(BCD1), tens);
    chk({name, "_bcd0"}, int'(BCD0), units);
    chk({name, "_wrap"}, int'(wrap), w);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    #1 reset = 1'b1;
    #1 lit("reset", 0, 0, 0);
    cyc(2);
    reset = 1'b0;

    // 1: free count up, ten ticks in 40 cycles
    en = 1'b1; up = 1'b1;
    cyc(39);
    lit("t1_39", 0, 9, 0);
    cyc(1);
    lit("t1_40", 1, 0, 0);

    // 2: wrap up from 98
    en = 1'b0;
    do_load(8'h98);
    lit("t2_load", 9, 8, 0);
    en = 1'b1;
    cyc(4);
    lit("t2_99", 9, 9, 0);
    cyc(4);
    lit("t2_00", 0, 0, 1);
    cyc(1);
    lit("t2_after", 0, 0, 0);

    // 3: wrap down from 00
    do_load(8'h00);
    up = 1'b0;
    cyc(4);
    lit("t3_99", 9, 9, 1);
    cyc(4);
    lit("t3_98", 9, 8, 0);

    // 4: clamped load, prescaler cleared
    do_load(8'hFC);
    lit("t4_load", 9, 9, 0);
    up = 1'b1;
    cyc(3);
    lit("t4_hold", 9, 9, 0);
    cyc(1);
    lit("t4_tick", 0, 0, 1);

    // 5: load in the tick cycle wins
    do_load(8'h10);
    cyc(3);
    do_load(8'h42);
    lit("t5_load", 4, 2, 0);
    cyc(3);
    lit("t5_hold", 4, 2, 0);
    cyc(1);
    lit("t5_tick", 4, 3, 0);

    // 6: hold, async reset, resume
    do_load(8'h36);
    cyc(4);
    lit("t6_37", 3, 7, 0);
    en = 1'b0;
    cyc(10);
    lit("t6_held", 3, 7, 0);
    #2 reset = 1'b1;
    #1 lit("t6_async", 0, 0, 0);
    cyc(1);
    reset = 1'b0;
    en = 1'b1;
    cyc(3);
    lit("t6_wait", 0, 0, 0);
    cyc(1);
    lit("t6_01", 0, 1, 0);

    // down-count crossing a tens boundary
    do_load(8'h20);
    up = 1'b0;
    cyc(4);
    lit("dn_19", 1, 9, 0);

    en = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
